// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with valid/ready load handshake, one bit per clock on sout.
// Optional even-parity bit after each word: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
  localparam logic [CW-1:0] NEXT_LAST = CW'(WIDTH - 2);

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_sh;
  logic             accept;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par;
`endif

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign accept  = load_valid && load_ready;
  assign next_sh = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // Outputs are registered: each edge computes what the following cycle presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is only possible from IDLE or a word's final cycle, so it always starts a fresh word.
      state      <= SHIFT;
      cnt        <= '0;
      shreg      <= din;
      sout       <= head(din);
      sout_valid <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      load_ready <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par        <= ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state      <= PARITY;
            sout       <= par;
            sout_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b1;
            load_ready <= 1'b1;
`else
            state      <= IDLE;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`endif
          end else begin
            cnt        <= cnt + CW'(1);
            shreg      <= next_sh;
            sout       <= head(next_sh);
            sout_valid <= 1'b1;
            busy       <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            done       <= 1'b0;
            load_ready <= 1'b0;
`else
            done       <= (cnt == NEXT_LAST);
            load_ready <= (cnt == NEXT_LAST);
`endif
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based reference model plus directed and random steps.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       load_valid;
  logic       load_ready, sout, sout_valid, busy, done;

  logic [7:0] din_l;
  logic       lv_l;
  logic       ready_l, sout_l, valid_l, busy_l, done_l;

  logic [2:0] din_3;
  logic       lv_3;
  logic       ready_3, sout_3, valid_3, busy_3, done_3;

  int errors = 0;
  int checks = 0;

  // Reference: queue of {done, bit} still to be presented, front = current cycle.
  logic [1:0] exp_q[$];
  logic       exp_ready = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(load_ready),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_l), .load_valid(lv_l), .load_ready(ready_l),
    .sout(sout_l), .sout_valid(valid_l), .busy(busy_l), .done(done_l));

  piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b1)) u_w3 (
    .clk(clk), .rst(rst), .din(din_3), .load_valid(lv_3), .load_ready(ready_3),
    .sout(sout_3), .sout_valid(valid_3), .busy(busy_3), .done(done_3));

  function automatic logic [32:0] serial_bits(input logic [31:0] w, input int width, input bit msb);
    logic [32:0] r;
    logic p;
    r = '0;
    p = 1'b0;
    for (int i = 0; i < width; i++) begin
      r[i] = msb ? w[width-1-i] : w[i];
      p ^= w[i];
    end
    if (PAR != 0) r[width] = p;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the main DUT: advance the model on the edge, then compare all outputs.
  task automatic tick();
    logic        acc;
    logic [7:0]  w;
    logic [32:0] bits;
    int          n;
    logic        sv;
    acc = !rst && load_valid && exp_ready;
    w   = din;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_ready = 1'b0;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        bits = serial_bits(32'(w), 8, 1'b1);
        n = 8 + PAR;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), bits[i]});
      end
      exp_ready = (exp_q.size() <= 1);
    end
    #1;
    sv = (exp_q.size() > 0);
    chk("load_ready", 32'(load_ready), 32'(exp_ready));
    chk("sout_valid", 32'(sout_valid), 32'(sv));
    chk("busy",       32'(busy),       32'(sv));
    chk("sout",       32'(sout),       sv ? 32'(exp_q[0][0]) : 32'd0);
    chk("done",       32'(done),       sv ? 32'(exp_q[0][1]) : 32'd0);
  endtask

  initial begin
    logic [32:0] bits;
    logic [2:0]  det;
    int          n;

    rst = 1'b1; load_valid = 1'b0; din = '0;
    din_l = '0; lv_l = 1'b0; din_3 = '0; lv_3 = 1'b0;

    // Reset for two cycles, with a load offered that must be ignored.
    load_valid = 1'b1; din = 8'h3C;
    tick();
    tick();
    load_valid = 1'b0;
    rst = 1'b0;
    repeat (3) tick();

    // MSB-first A5; din scrambled while shifting must not matter.
    din = 8'hA5; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      din = 8'($urandom);
      tick();
    end

    // Back-to-back 05 then FF, second word offered in the first word's final cycle.
    din = 8'h05; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 20 && !exp_ready; i++) tick();
    chk("b2b_ready_reached", 32'(exp_ready), 32'd1);
    din = 8'hFF; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (12) tick();

    // Reset on the 4th bit of F0, then a clean 81.
    din = 8'hF0; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    din = 8'h81; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (12) tick();

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      din        = 8'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0; load_valid = 1'b0;
    repeat (12) tick();

    // LSB-first 07 on the second instance.
    @(negedge clk);
    chk("lsb_ready_idle", 32'(ready_l), 32'd1);
    din_l = 8'h07; lv_l = 1'b1;
    @(posedge clk); #1;
    lv_l = 1'b0; din_l = 8'hFF;
    bits = serial_bits(32'h07, 8, 1'b0);
    n = 8 + PAR;
    for (int i = 0; i < n; i++) begin
      chk("lsb_valid", 32'(valid_l), 32'd1);
      chk("lsb_sout",  32'(sout_l),  32'(bits[i]));
      chk("lsb_done",  32'(done_l),  32'(i == n - 1));
      @(posedge clk); #1;
    end
    chk("lsb_idle_valid", 32'(valid_l), 32'd0);
    chk("lsb_idle_sout",  32'(sout_l),  32'd0);

    // WIDTH=3 word 101 feeding a 101 sequence detector.
    din_3 = 3'b101; lv_3 = 1'b1;
    @(posedge clk); #1;
    lv_3 = 1'b0;
    bits = serial_bits(32'b101, 3, 1'b1);
    det = '0;
    for (int i = 0; i < 3; i++) begin
      chk("w3_sout", 32'(sout_3), 32'(bits[i]));
      chk("w3_valid", 32'(valid_3), 32'd1);
      if (valid_3) det = {det[1:0], sout_3};
      if (i == 2) chk("w3_detect_q", 32'(det == 3'b101), 32'd1);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the FSM serial sequence detectors. It accepts a parallel word through a valid/ready handshake and emits it one bit per clock on `sout`, qualified by `sout_valid`. `sout` drives a detector's `in` input. An optional even-parity bit can be appended after each word.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts the MSB out first; 0 shifts the LSB out first.
- `clk`  in  1  single clock; everything updates on posedge.
- `rst`  in  1  synchronous, active-high reset, sampled on posedge `clk`.
- `din`  in  WIDTH  parallel word; sampled only on accept.
- `load_valid`  in  1  `din` is valid.
- `load_ready`  out  1  block can accept a word this cycle.
- `sout`  out  1  serial data bit (registered).
- `sout_valid`  out  1  `sout` carries a data or parity bit.
- `busy`  out  1  a word is being shifted (state is not IDLE).
- `done`  out  1  one-cycle pulse, coincident with the last serial bit of a word.

## Operation
- Accept occurs when `load_valid && load_ready` at a posedge.
- `load_ready` is a function of state only; it never depends on `load_valid`.
- States:
  - **IDLE**: `load_ready`=1, `sout_valid`=0, `sout`=0. On accept: load the shift register, set bit counter to 0, go to SHIFT.
  - **SHIFT**: present the current bit with `sout_valid`=1; counter increments each cycle.
    - At counter = WIDTH-1 with parity compiled out: last bit, `done`=1, `load_ready`=1. An accept in this cycle reloads and stays in SHIFT with no bubble; otherwise go to IDLE.
    - At counter = WIDTH-1 with parity compiled in: go to PARITY; `load_ready`=0 in this cycle.
  - **PARITY** (parity builds only): `sout` = XOR of the accepted word, `sout_valid`=1, `done`=1, `load_ready`=1. An accept here goes to SHIFT with no bubble; otherwise go to IDLE.
- The shift register holds a private copy of the word. Changes on `din` after accept have no effect.
- Counter width is clog2(WIDTH). It never wraps past WIDTH-1.
- `rst` has priority over everything, including an in-progress word. The partial word is discarded, and an accept in the reset cycle is ignored.

## Timing
- Reset values: `sout`=0, `sout_valid`=0, `done`=0, `busy`=0, state IDLE. `load_ready`=0 while `rst`=1, then 1 from the first cycle after release.
- Latency: a word accepted at edge k presents its first bit during cycle k+1, after edge k.
- Per-word occupancy: WIDTH cycles, or WIDTH+1 with parity.
- Back-to-back words give a gap-free `sout_valid` stream.
- `sout` returns to 0 in any cycle where `sout_valid`=0.

## Configuration
- Macro: `PISO_SERIALIZER_PARITY_EN`.
- Defined:
  - PARITY state present.
  - One even-parity bit (XOR of all data bits) follows the data bits.
  - `done` is asserted on the parity bit.
- Undefined:
  - PARITY state and XOR logic are absent.
  - `done` is asserted on the last data bit.
  - Occupancy is exactly WIDTH cycles.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, release, `load_valid`=0.
  - Required: `load_ready`=0 during reset, then 1. `sout`=`sout_valid`=`busy`=`done`=0 throughout.
- MSB-first word (WIDTH=8, MSB_FIRST=1, no parity):
  - Stimulus: `din`=8'hA5 accepted.
  - Required: `sout` = 1,0,1,0,0,1,0,1 on the next 8 cycles with `sout_valid`=1. `done` is high only on the 8th bit. IDLE follows.
- LSB-first word with parity (MSB_FIRST=0, macro defined):
  - Stimulus: `din`=8'h07 accepted.
  - Required: `sout` = 1,1,1,0,0,0,0,0, then parity bit 1. `done` is on the 9th bit.
- Back-to-back words (no parity):
  - Stimulus: 8'h05 accepted; 8'hFF offered with `load_valid`=1 and accepted in the last-bit cycle.
  - Required: 16 contiguous `sout_valid` cycles, output 00000101 then 11111111. `done` pulses at bits 8 and 16.
- Reset mid-word:
  - Stimulus: assert `rst` on the 4th bit of 8'hF0.
  - Required: the next cycle shows `sout_valid`=0 and `busy`=0. After release, 8'h81 shifts out cleanly as 1,0,0,0,0,0,0,1.
- Integration with the detector (WIDTH=3, MSB_FIRST=1):
  - Stimulus: `din`=3'b101 drives the detector's `in`.
  - Required: the detector's `q`=1 in the cycle the third bit (1) is presented.
